// File: rtl/taylor_asin_rtl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : taylor_asin_rtl
// Description : Sequential fixed-point arcsine using a truncated Taylor series.
//               asin(x) = x + sum_{k=0..4} c[k] * x^(2k+3). One multiplier
//               operation per state. Output is held until start_in drops.
//               Optional input clamp with range flag: TAYLOR_ASIN_CLAMP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module taylor_asin_rtl #(
    parameter int FXP_SHIFT = 10,
    parameter int W         = 12
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start_in,
    input  logic [W-1:0] x_in,
    output logic         ready_out,
    output logic [W-1:0] asin_out
`ifdef TAYLOR_ASIN_CLAMP_EN
    ,
    output logic         range_err_out
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SQ   = 3'd1,
        S_PMUL = 3'd2,
        S_CMUL = 3'd3,
        S_ACC  = 3'd4,
        S_DONE = 3'd5,
        S_HOLD = 3'd6
    } state_t;

    localparam logic [2:0] c_last_k = 3'd4;

    // Series coefficients in Q10: 1/6, 3/40, 15/336, 105/3456, 945/42240.
    function automatic logic signed [W-1:0] coef(input logic [2:0] k);
        logic signed [W-1:0] c;
        case (k)
            3'd0:    c = W'(171);
            3'd1:    c = W'(77);
            3'd2:    c = W'(46);
            3'd3:    c = W'(31);
            3'd4:    c = W'(23);
            default: c = '0;
        endcase
        return c;
    endfunction

    // Full-width signed product, floor shift back to Q format, keep low W bits.
    function automatic logic signed [W-1:0] fmul(input logic signed [W-1:0] a,
                                                 input logic signed [W-1:0] b);
        logic signed [2*W-1:0] prod;
        prod = a * b;
        return W'(prod >>> FXP_SHIFT);
    endfunction

    state_t                r_state;
    state_t                w_next;
    logic signed [W-1:0]   r_x;
    logic signed [W-1:0]   r_x2;
    logic signed [W-1:0]   r_p;
    logic signed [W-1:0]   r_t;
    logic signed [W+1:0]   r_acc;
    logic [2:0]            r_k;
    logic signed [W-1:0]   w_x_cap;
    logic [W-1:0]          w_sat;

`ifdef TAYLOR_ASIN_CLAMP_EN
    localparam logic signed [W-1:0] c_one = W'(1 << FXP_SHIFT);
    logic w_oor;

    // Clamp the operand to [-1.0, +1.0] and flag when clamping occurred.
    always_comb begin
        w_x_cap = $signed(x_in);
        w_oor   = 1'b0;
        if ($signed(x_in) > c_one) begin
            w_x_cap = c_one;
            w_oor   = 1'b1;
        end else if ($signed(x_in) < -c_one) begin
            w_x_cap = -c_one;
            w_oor   = 1'b1;
        end
    end
`else
    // Operand passes through unmodified.
    always_comb begin
        w_x_cap = $signed(x_in);
    end
`endif

    // Saturate the widened accumulator back into W bits.
    always_comb begin
        if ((r_acc[W+1:W-1] == 3'b000) || (r_acc[W+1:W-1] == 3'b111)) begin
            w_sat = r_acc[W-1:0];
        end else if (r_acc[W+1]) begin
            w_sat = {1'b1, {(W-1){1'b0}}};
        end else begin
            w_sat = {1'b0, {(W-1){1'b1}}};
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state sequencing: square, then five power/coefficient/accumulate rounds.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start_in) w_next = S_SQ;
            S_SQ:    w_next = S_PMUL;
            S_PMUL:  w_next = S_CMUL;
            S_CMUL:  w_next = S_ACC;
            S_ACC:   w_next = (r_k == c_last_k) ? S_DONE : S_PMUL;
            S_DONE:  w_next = S_HOLD;
            S_HOLD:  if (!start_in) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath and output registers; each state performs one arithmetic step.
    always_ff @(posedge clock) begin
        if (reset) begin
            ready_out <= 1'b0;
            asin_out  <= '0;
            r_x       <= '0;
            r_x2      <= '0;
            r_p       <= '0;
            r_t       <= '0;
            r_acc     <= '0;
            r_k       <= '0;
`ifdef TAYLOR_ASIN_CLAMP_EN
            range_err_out <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_in) begin
                        r_x       <= w_x_cap;
                        r_acc     <= {{2{w_x_cap[W-1]}}, w_x_cap};
                        ready_out <= 1'b0;
`ifdef TAYLOR_ASIN_CLAMP_EN
                        range_err_out <= w_oor;
`endif
                    end
                end
                S_SQ: begin
                    r_x2 <= fmul(r_x, r_x);
                    r_p  <= r_x;
                    r_k  <= '0;
                end
                S_PMUL: begin
                    r_p <= fmul(r_p, r_x2);
                end
                S_CMUL: begin
                    r_t <= fmul(r_p, coef(r_k));
                end
                S_ACC: begin
                    r_acc <= r_acc + {{2{r_t[W-1]}}, r_t};
                    r_k   <= r_k + 3'd1;
                end
                S_DONE: begin
                    asin_out  <= w_sat;
                    ready_out <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_taylor_asin_rtl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_taylor_asin_rtl
// Description : Directed self-checking bench for taylor_asin_rtl with
//               hand-computed expected results and latency checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_taylor_asin_rtl;

    logic               clock    = 1'b0;
    logic               reset    = 1'b1;
    logic               start_in = 1'b0;
    logic signed [11:0] x_in     = '0;
    wire                ready_out;
    wire signed  [11:0] asin_out;
`ifdef TAYLOR_ASIN_CLAMP_EN
    wire                range_err_out;
`endif

    int n_cmp = 0;
    int n_err = 0;

    taylor_asin_rtl #(.FXP_SHIFT(10), .W(12)) dut (
        .clock         (clock),
        .reset         (reset),
        .start_in      (start_in),
        .x_in          (x_in),
        .ready_out     (ready_out),
        .asin_out      (asin_out)
`ifdef TAYLOR_ASIN_CLAMP_EN
        ,
        .range_err_out (range_err_out)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One computation. chg_at: edge at which x_in changes to x_alt (0 = never).
    // rst_at: edge at which reset is seen high (0 = never); the task then
    // returns with reset still asserted. hold: keep start_in high after done.
    task automatic run(input int x, input int chg_at, input int x_alt,
                       input int rst_at, input bit hold, input int exp,
                       input string tag);
        int n;
        bit seen;
        start_in = 1'b0;
        repeat (2) @(negedge clock);
        reset    = 1'b0;
        x_in     = 12'(x);
        start_in = 1'b1;
        @(posedge clock);
        n = 1;
        #1;
        check({tag, " ready low after accept"}, int'(ready_out), 0);
        if (!hold) start_in = 1'b0;
        seen = 1'b0;
        while (n < 40 && !seen) begin
            if (n == chg_at - 1) x_in = 12'(x_alt);
            if (n == rst_at - 1) reset = 1'b1;
            @(posedge clock);
            n++;
            #1;
            if (n == rst_at) begin
                check({tag, " ready after reset"}, int'(ready_out), 0);
                check({tag, " asin after reset"}, int'(asin_out), 0);
                return;
            end
            if (ready_out === 1'b1) seen = 1'b1;
        end
        check({tag, " latency"}, n, 18);
        check({tag, " asin"}, int'(asin_out), exp);
        if (hold) begin
            repeat (3) @(posedge clock);
            #1;
            check({tag, " ready held"}, int'(ready_out), 1);
            check({tag, " asin held"}, int'(asin_out), exp);
            start_in = 1'b0;
            repeat (2) @(posedge clock);
            #1;
            check({tag, " asin kept in idle"}, int'(asin_out), exp);
        end
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check("reset ready", int'(ready_out), 0);
        check("reset asin", int'(asin_out), 0);
`ifdef TAYLOR_ASIN_CLAMP_EN
        check("reset range_err", int'(range_err_out), 0);
`endif

        run(0,     0, 0,   0, 1'b0, 0,     "x0");
        run(512,   0, 0,   0, 1'b0, 535,   "x512");
        run(-512,  0, 0,   0, 1'b0, -540,  "xm512");
        run(256,   0, 0,   0, 1'b0, 258,   "x256");
        run(-1024, 0, 0,   0, 1'b0, -1372, "xm1024");
        run(1024,  0, 0,   0, 1'b1, 1372,  "x1024 hold");
        run(512,   5, 300, 0, 1'b0, 535,   "x change ignored");
        run(1024,  0, 0,   9, 1'b0, 0,     "mid reset");
        // reset released together with start_in high: first edge accepts
        run(512,   0, 0,   0, 1'b0, 535,   "start after reset");

`ifdef TAYLOR_ASIN_CLAMP_EN
        run(1500,  0, 0,   0, 1'b0, 1372,  "clamp hi");
        check("clamp hi range_err", int'(range_err_out), 1);
        run(-200,  0, 0,   0, 1'b0, -206,  "in range");
        check("in range range_err", int'(range_err_out), 0);
        run(-1500, 0, 0,   0, 1'b0, -1372, "clamp lo");
        check("clamp lo range_err", int'(range_err_out), 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/taylor_asin_rtl.md
TAYLOR_ASIN_RTL -- requirements
Module: taylor_asin_rtl

Interface
REQ-001 Parameter FXP_SHIFT, default 10: fractional bits of every fixed-point quantity (Q2.10 in 12 bits).
REQ-002 Parameter W, default 12: width of input, output and working registers.
REQ-003 Port clock  in  1  single clock; all state changes on rising edge.
REQ-004 Port reset  in  1  synchronous, active-high reset.
REQ-005 Port start_in  in  1  request level; a new computation starts when seen high in IDLE.
REQ-006 Port x_in  in  W  signed sine value, Q2.10; valid range -1024..1024.
REQ-007 Port ready_out  out  1  result valid; held until start_in is seen low.
REQ-008 Port asin_out  out  W  signed arcsine result in radians, Q2.10.
REQ-009 Port range_err_out  out  1  input was out of range; present only with TAYLOR_ASIN_CLAMP_EN.

Function
REQ-010 Compute asin(x) = x + sum over k=0..4 of c[k]*x^(2k+3); c = {171, 77, 46, 31, 23} (1/6, 3/40, 15/336, 105/3456, 945/42240 in Q10), held in a constant table.
REQ-011 Every multiply: full 2W-bit signed product, arithmetic shift right FXP_SHIFT (floor), keep low W bits.
REQ-012 States: IDLE, SQ, PMUL, CMUL, ACC, DONE, HOLD.
REQ-013 IDLE: on start_in=1 -> capture x_in into x_r, acc <= x_in, ready_out <= 0, go SQ; else stay.
REQ-014 SQ: x2 <= (x_r*x_r)>>>10; p <= x_r; k <= 0; go PMUL.
REQ-015 PMUL: p <= (p*x2)>>>10; go CMUL.
REQ-016 CMUL: t <= (p*c[k])>>>10; go ACC.
REQ-017 ACC: acc <= acc + t (acc W+2 bits signed); k <= k+1; k==4 -> DONE, else PMUL.
REQ-018 DONE: asin_out <= acc saturated to [-2048, 2047]; ready_out <= 1; go HOLD.
REQ-019 HOLD: start_in=0 -> IDLE; else stay; ready_out and asin_out held.
REQ-020 Latency: ready_out rises on the 18th rising edge, counting the edge that accepts start_in as edge 1.
REQ-021 start_in changes and x_in changes outside the accepting edge are ignored while busy.
REQ-022 asin_out keeps the last result from DONE until the next DONE or reset.

Reset
REQ-023 reset=1 at any edge, including mid-computation: state <= IDLE, ready_out <= 0, asin_out <= 0, range_err_out <= 0; the in-flight result is discarded.
REQ-024 If start_in is high on the first edge after reset is released, a new computation starts.

Configuration
REQ-025 Macro TAYLOR_ASIN_CLAMP_EN defined: at the accepting edge x_in > 1024 is captured as 1024, x_in < -1024 as -1024, and range_err_out <= 1 (else 0); range_err_out updates only at the accepting edge and is held otherwise.
REQ-026 Macro undefined: no clamp and no range_err_out port; |x_in| > 1024 gives a deterministic but unspecified asin_out, with latency unchanged.

Verification
REQ-027 x_in=0, start pulse -> ready_out rises on edge 18, asin_out=0.
REQ-028 x_in=512 -> asin_out=535; x_in=-512 -> asin_out=-540 (floor asymmetry).
REQ-029 x_in=1024 -> asin_out=1372; start_in held high -> stays in HOLD, ready_out=1 until start_in drops, then back to IDLE.
REQ-030 reset asserted at edge 9 of a computation -> ready_out=0 and asin_out=0 next cycle; a new start with x_in=512 then gives 535.
REQ-031 TAYLOR_ASIN_CLAMP_EN defined, x_in=1500 -> asin_out=1372, range_err_out=1; then x_in=-200 -> range_err_out=0.
REQ-032 x_in changed to 300 at edge 5 of a computation started with 512 -> asin_out=535.
